// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks registers 0..NREGS-1 through one asynchronous
// register-file read port and streams each as (address, data) over a
// valid/ready interface for the debug UART / trace FIFO.
module regfile_dump_reader #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 5,
    parameter int NREGS  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    output logic [WIDTH-1:0]  RA,
    input  logic [DWIDTH-1:0] RD,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DWIDTH-1:0] Out_Data,
    output logic [WIDTH-1:0]  Out_Addr,
    output logic              Out_Last,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD,
        ST_DONE
    } state_t;

    // One extra index bit so NREGS == 2**WIDTH reaches the last register
    // without the counter wrapping.
    localparam logic [WIDTH:0] LAST_IDX = (WIDTH+1)'(NREGS - 1);
    localparam logic [WIDTH:0] IDX_ONE  = (WIDTH+1)'(1);

    state_t              state_reg, state_next;
    logic [WIDTH:0]      index_reg, index_next;
    logic                start_reg, start_next;
    logic [WIDTH-1:0]    ra_reg, ra_next;
    logic                valid_reg, valid_next;
    logic [DWIDTH-1:0]   data_reg, data_next;
    logic [WIDTH-1:0]    addr_reg, addr_next;
    logic                last_reg, last_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    assign RA        = ra_reg;
    assign Out_Valid = valid_reg;
    assign Out_Data  = data_reg;
    assign Out_Addr  = addr_reg;
    assign Out_Last  = last_reg;
    assign Busy      = busy_reg;
    assign Done      = done_reg;

    // State and output registers; reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            start_reg <= 1'b0;
            ra_reg    <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            addr_reg  <= '0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            start_reg <= start_next;
            ra_reg    <= ra_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            addr_reg  <= addr_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and next-output logic for the dump sequencer.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        ra_next    = ra_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        addr_next  = addr_reg;
        last_next  = last_reg;

        // Start is registered once before the sequencer acts on it, so the
        // first word appears two edges after the Start edge. Only a fresh
        // request seen while idle is latched; requests in any other state
        // (including the Done cycle) are dropped.
        start_next = (state_reg == ST_IDLE) && !start_reg && Start;

        case (state_reg)
            ST_IDLE: begin
                ra_next = '0;
                if (start_reg) begin
                    index_next = '0;
                    ra_next    = '0;
                    state_next = ST_READ;
                end
            end

            ST_READ: begin
                if (Abort) begin
                    ra_next    = '0;
                    state_next = ST_IDLE;
                end else begin
                    // RD reflects RA == index this cycle; capture it now so
                    // each word is coherent with its own capture edge.
                    data_next  = RD;
                    addr_next  = index_reg[WIDTH-1:0];
                    last_next  = (index_reg == LAST_IDX);
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (Abort) begin
                    valid_next = 1'b0;
                    ra_next    = '0;
                    state_next = ST_IDLE;
                end else if (Out_Ready) begin
                    valid_next = 1'b0;
                    if (last_reg) begin
                        ra_next    = '0;
                        state_next = ST_DONE;
                    end else begin
                        index_next = index_reg + IDX_ONE;
                        ra_next    = index_next[WIDTH-1:0];
                        state_next = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                ra_next    = '0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_READ) || (state_next == ST_HOLD);
        done_next = (state_next == ST_DONE);
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a timeline model of the dump protocol
// (word k valid two edges after the start edge plus two per earlier word,
// data read from the bench's register file at the capture edge) checked
// against the DUT every cycle, plus directed scenarios with literal checks.
module tb_regfile_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          Clk = 1'b0;
    logic          Rst, Start, Abort, Out_Ready;
    logic [AW-1:0] RA;
    logic [DW-1:0] RD;
    logic          Out_Valid, Out_Last, Busy, Done;
    logic [DW-1:0] Out_Data;
    logic [AW-1:0] Out_Addr;

    logic [DW-1:0] regs [NR];
    assign RD = regs[RA];

    regfile_dump_reader #(.DWIDTH(DW), .WIDTH(AW), .NREGS(NR)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
        .RA(RA), .RD(RD),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Data(Out_Data), .Out_Addr(Out_Addr), .Out_Last(Out_Last),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Model state: a dump is "active" from the Start edge until completion.
    // m_wait counts edges until the next word becomes valid.
    bit            m_active, m_valid, m_done;
    int            m_wait, m_addr;
    logic [DW-1:0] m_data;
    int            log_addr[$];
    logic [DW-1:0] log_data[$];

    int done_seen;
    int done_cyc;
    int start_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Protocol model, advanced on every rising edge from the sampled inputs.
    initial forever begin
        bit was_done;
        @(posedge Clk);
        if (Rst) begin
            m_active = 0; m_valid = 0; m_done = 0; m_wait = 0; m_addr = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            if (!m_active) begin
                if (Start && !was_done) begin
                    m_active = 1; m_addr = 0; m_wait = 2;
                end
            end else if (m_valid) begin
                if (Abort) begin
                    m_active = 0; m_valid = 0;
                end else if (Out_Ready) begin
                    $display("word addr=%0d data=%h last=%0d", m_addr, m_data, m_addr == NR-1);
                    log_addr.push_back(m_addr);
                    log_data.push_back(m_data);
                    m_valid = 0;
                    if (m_addr == NR-1) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_addr++; m_wait = 1;
                    end
                end
            end else begin
                // m_wait==2 is the cycle before reading starts: Abort ignored.
                if (m_wait == 1 && Abort) begin
                    m_active = 0;
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_valid = 1;
                        m_data  = regs[m_addr];
                    end
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    initial forever begin
        bit m_busy;
        @(negedge Clk);
        if (Done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (chk_en) begin
            m_busy = m_active && !m_valid ? (m_wait != 2) : m_active;
            chk("out_valid", Out_Valid, m_valid);
            chk("busy", Busy, m_busy);
            chk("done", Done, m_done);
            if (m_active || !m_done)
                chk("ra", RA, m_active ? m_addr : 0);
            if (m_valid) begin
                chk("out_addr", Out_Addr, m_addr);
                chk("out_data", Out_Data, m_data);
                chk("out_last", Out_Last, m_addr == NR-1);
            end
        end
    end

    task automatic preload();
        regs[0] = 32'h0;
        regs[1] = 32'hA5A5A5A5;
        regs[2] = 32'h5A5A5A5A;
        for (int i = 3; i < NR; i++) regs[i] = i;
    endtask

    task automatic run_start();
        @(negedge Clk);
        log_addr.delete();
        log_data.delete();
        done_seen = 0;
        Start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_word(input int a, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Out_Valid === 1'b1 && Out_Addr == a) return;
        end
        timeout($sformatf("wait_word_%0d", a));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (done_seen > 0) begin
                @(negedge Clk);
                return;
            end
        end
        timeout("wait_done");
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ra"}, RA, 0);
        chk({tag, "_valid"}, Out_Valid, 0);
        chk({tag, "_data"}, Out_Data, 0);
        chk({tag, "_addr"}, Out_Addr, 0);
        chk({tag, "_last"}, Out_Last, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Out_Ready = 1'b1;
        done_seen = 0; done_cyc = 0; start_cyc = 0;
        preload();
        repeat (3) @(negedge Clk);
        chk_outputs_zero("reset");
        Rst = 1'b0;
        chk_en = 1;

        // Full dump, no backpressure.
        run_start();
        wait_done(200);
        chk("full_count", log_addr.size(), 32);
        if (log_addr.size() == 32) begin
            chk("full_w0_data", log_data[0], 32'h0);
            chk("full_w1_data", log_data[1], 32'hA5A5A5A5);
            chk("full_w2_data", log_data[2], 32'h5A5A5A5A);
            chk("full_w31_addr", log_addr[31], 31);
            chk("full_w31_data", log_data[31], 32'd31);
        end
        chk("full_done_count", done_seen, 1);
        chk("full_done_latency", done_cyc - start_cyc, 65);

        // Backpressure on addr 2, then Start while busy at word 10.
        run_start();
        wait_word(2, 20);
        Out_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_valid", Out_Valid, 1);
            chk("bp_data", Out_Data, 32'h5A5A5A5A);
            chk("bp_addr", Out_Addr, 2);
        end
        Out_Ready = 1'b1;
        wait_word(10, 40);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(200);
        chk("bp_count", log_addr.size(), 32);
        if (log_addr.size() == 32) chk("bp_w11_addr", log_addr[11], 11);
        chk("bp_done_count", done_seen, 1);

        // Concurrent writes: r20 before its capture, r3 after its handshake.
        preload();
        run_start();
        wait_word(3, 20);
        @(negedge Clk);
        regs[3] = 32'h12345678;
        wait_word(5, 20);
        regs[20] = 32'hDEADBEEF;
        wait_done(200);
        chk("cw_count", log_addr.size(), 32);
        if (log_addr.size() == 32) begin
            chk("cw_w20_data", log_data[20], 32'hDEADBEEF);
            chk("cw_w3_data", log_data[3], 32'd3);
        end

        // Abort in HOLD at addr 7, then restart.
        preload();
        run_start();
        wait_word(7, 40);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_valid", Out_Valid, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        repeat (3) @(negedge Clk);
        chk("abort_done_count", done_seen, 0);
        chk("abort_count", log_addr.size(), 7);
        run_start();
        wait_done(200);
        chk("abort_restart_count", log_addr.size(), 32);
        if (log_addr.size() > 0) chk("abort_restart_first", log_addr[0], 0);

        // Reset mid-dump at word 15, then restart.
        run_start();
        wait_word(15, 60);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk_outputs_zero("midrst");
        repeat (3) @(negedge Clk);
        chk("midrst_done_count", done_seen, 0);
        chk("midrst_count", log_addr.size(), 15);
        run_start();
        wait_done(200);
        chk("midrst_restart_count", log_addr.size(), 32);
        if (log_addr.size() > 0) chk("midrst_restart_first", log_addr[0], 0);

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace engine that walks every architectural register through one asynchronous read port of the register file.
- Streams each register as (address, data) over a valid/ready output, for the debug UART/trace FIFO.
- Sits beside the core's REGISTER_FILE on a spare read port. It is the sequential reader opposite the writeback path that writes the file.

Parameters:
- DWIDTH, 32, register data width
- WIDTH, 5, register address width
- NREGS, 32, registers dumped (addresses 0..NREGS-1, NREGS <= 2**WIDTH)

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous active-high reset
- Start  in  1  begin dump; sampled only in IDLE
- Abort  in  1  cancel dump; sampled in READ/HOLD
- RA  out  WIDTH  read address to register file read port (registered)
- RD  in  DWIDTH  combinational read data from register file for RA
- Out_Valid  out  1  output word valid
- Out_Ready  in  1  consumer accepts word when Out_Valid & Out_Ready
- Out_Data  out  DWIDTH  captured register value
- Out_Addr  out  WIDTH  register index of Out_Data
- Out_Last  out  1  Out_Data is register NREGS-1
- Busy  out  1  high in READ/HOLD
- Done  out  1  one-cycle pulse on dump completion

Behaviour:
- Reset (Rst high at an edge): state IDLE; RA, Out_Data, Out_Addr = 0; Out_Valid, Out_Last, Busy, Done = 0; index counter = 0. Rst has priority over every other input.
- The FSM has four states, and all outputs are registered.
- IDLE: RA = 0, Busy = 0.
  - Start=1 sets index=0 and RA=0, then goes to READ.
  - Abort is ignored.
- READ: one cycle, RA = index, Busy = 1.
  - At the edge: Out_Data<=RD, Out_Addr<=index, Out_Last<=(index==NREGS-1), Out_Valid<=1, then go to HOLD.
  - Abort=1 in READ goes to IDLE; no word is produced.
- HOLD: Out_Valid = 1. Out_Data, Out_Addr and Out_Last stay stable until the handshake.
  - Handshake with Out_Last=0: Out_Valid<=0, index<=index+1, RA<=index+1, go to READ.
  - Handshake with Out_Last=1: Out_Valid<=0, go to DONE.
  - Abort=1 (with or without Ready): Out_Valid<=0, go to IDLE, no Done. This is the only legal withdrawal of Out_Valid.
- DONE: Done = 1 and Busy = 0 for exactly one cycle, then IDLE. Start is ignored in DONE.
- Timing: Start sampled at edge E gives the first Out_Valid after edge E+2. With Out_Ready tied high, there is one word every 2 cycles. Word k is valid after edge E+2+2k. The last handshake is at edge E+2*NREGS+1, and Done is high after that edge.
- Start while Busy: ignored; no restart and no counter change.
- Coherence: each word is the register value at its own capture edge, not a snapshot of the whole file. A writeback to register k before k's READ edge is reflected. A write after the capture is not.
- Register 0 is dumped like any other and reads 0 from the file.
- index is WIDTH+1 bits internally, so NREGS = 2**WIDTH does not wrap before Out_Last.
- Reset mid-dump: outputs go to reset values at the next edge. No Done. A partial word may be lost.

Test Plan:
- Full dump, no backpressure: preload r1=A5A5A5A5, r2=5A5A5A5A, rN=N for N>=3, pulse Start, Out_Ready=1 -> 32 words with addr 0..31 and data 0, A5A5A5A5, 5A5A5A5A, 3..31. Out_Last only on addr 31. Done pulses once, 65 cycles after the Start edge.
- Backpressure: Out_Ready low for 5 cycles while addr 2 is valid -> Out_Valid, Out_Data=5A5A5A5A and Out_Addr=2 are held stable. Addr 3 is not issued until the handshake. Total word count is still 32.
- Start while busy: pulse Start again at word 10 -> ignored. Sequence continues 11..31 and Done pulses once.
- Abort in HOLD at addr 7 -> Out_Valid drops next cycle, Busy=0, no Done. A following Start restarts at addr 0.
- Concurrent write: write r20=DEADBEEF while word 5 is valid -> word 20 reports DEADBEEF. Write r3=12345678 after word 3 is accepted -> the reported word 3 keeps its old value.
- Reset mid-dump at word 15 (Rst high one cycle) -> all outputs 0 next cycle, state IDLE, no Done. The next Start dumps from addr 0.
